// File: rtl/rv32i_lsu_pkg.sv
// rtl/rv32i_lsu_pkg.sv - shared size codes, FSM states and helpers for the load/store unit
package rv32i_lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        SPLIT  = 3'd2,
        ERR    = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    function automatic logic [2:0] num_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    num_bytes = 3'd1;
            SZ_H:    num_bytes = 3'd2;
            SZ_W:    num_bytes = 3'd4;
            default: num_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_load_ext.sv
// rtl/rv32i_load_ext.sv - sign/zero extension of right-justified load data
module rv32i_load_ext
    import rv32i_lsu_pkg::*;
(
    input  logic [31:0] v,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ext
);

    always_comb begin
        case (size)
            SZ_B:    ext = uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            SZ_H:    ext = uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: ext = v;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - load/store unit driving a naturally aligned byte-banked data memory
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] baddr,
    output logic [31:0] bdi,
    input  logic [31:0] bdo,
    output logic        bwr,
    output logic [1:0]  bsz
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  k_q;
    logic [31:0] buf_q;

    logic        misaligned;
    logic        last_byte;
    logic [31:0] split_val;
    logic [31:0] ext_in;
    logic [31:0] ext_out;

    assign misaligned = (req_size == SZ_H && req_addr[0]) ||
                        (req_size == SZ_W && req_addr[1:0] != 2'b00);
    assign last_byte  = ({1'b0, k_q} == num_bytes(size_q) - 3'd1);
    assign req_ready  = (state == IDLE);

    // Buffer with the byte arriving this cycle merged in, so the final byte can be extended directly.
    always_comb begin
        split_val = buf_q;
        split_val[{k_q, 3'b000} +: 8] = bdo[7:0];
    end

    assign ext_in = (state == SPLIT) ? split_val : bdo;

    rv32i_load_ext u_ext (
        .v    (ext_in),
        .size (size_q),
        .uns  (uns_q),
        .ext  (ext_out)
    );

    // Memory port is a pure decode of registered state.
    always_comb begin
        baddr = 32'h0;
        bdi   = 32'h0;
        bwr   = 1'b0;
        bsz   = SZ_W;
        case (state)
            ACCESS: begin
                baddr = addr_q;
                bsz   = size_q;
                bdi   = wdata_q;
                bwr   = we_q;
            end
            SPLIT: begin
                baddr = addr_q + {30'b0, k_q};
                bsz   = SZ_B;
                bdi   = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
                bwr   = we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            size_q    <= SZ_W;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            k_q       <= 2'd0;
            buf_q     <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        k_q     <= 2'd0;
                        buf_q   <= 32'h0;
                        if (req_size == SZ_ILL || (misaligned && ALLOW_MISALIGNED == 0)) begin
                            // The error response is presented in the ERR cycle itself.
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (misaligned) begin
                            state <= SPLIT;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= we_q ? 32'h0 : ext_out;
                end
                SPLIT: begin
                    buf_q <= split_val;
                    if (last_byte) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_q ? 32'h0 : ext_out;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                ERR, RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb/tb_rv32i_lsu.sv - directed self-checking bench for rv32i_lsu
module tb_rv32i_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid, e_req_valid;
    logic        req_ready, e_req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid, e_rsp_valid;
    logic [31:0] rsp_rdata, e_rsp_rdata;
    logic        rsp_err, e_rsp_err;
    logic [31:0] baddr, e_baddr;
    logic [31:0] bdi, e_bdi;
    logic [31:0] bdo;
    logic        bwr, e_bwr;
    logic [1:0]  bsz, e_bsz;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:1023];
    logic [31:0] wlog_addr [$];
    logic [7:0]  wlog_data [$];
    logic [31:0] seen_addr [$];
    logic [1:0]  seen_sz   [$];
    int          e_bwr_cnt = 0;

    rv32i_lsu #(.ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .baddr(baddr), .bdi(bdi), .bdo(bdo), .bwr(bwr), .bsz(bsz)
    );

    rv32i_lsu #(.ALLOW_MISALIGNED(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(e_req_valid), .req_ready(e_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(e_rsp_valid), .rsp_rdata(e_rsp_rdata), .rsp_err(e_rsp_err),
        .baddr(e_baddr), .bdi(e_bdi), .bdo(32'h0), .bwr(e_bwr), .bsz(e_bsz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-banked memory model: combinational read, write at the rising edge.
    always_comb begin
        logic [9:0] a;
        a = baddr[9:0];
        case (bsz)
            2'b00:   bdo = {24'b0, mem[a]};
            2'b01:   bdo = {16'b0, mem[a + 10'd1], mem[a]};
            default: bdo = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
        endcase
    end

    always @(posedge clk) begin
        logic [9:0] a;
        a = baddr[9:0];
        if (bwr) begin
            wlog_addr.push_back(baddr);
            wlog_data.push_back(bdi[7:0]);
            mem[a] <= bdi[7:0];
            if (bsz != 2'b00) mem[a + 10'd1] <= bdi[15:8];
            if (bsz == 2'b10) begin
                mem[a + 10'd2] <= bdi[23:16];
                mem[a + 10'd3] <= bdi[31:24];
            end
        end
        if (e_bwr) e_bwr_cnt++;
    end

    task automatic preload();
        for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        mem[10'h100] <= 8'h01; mem[10'h101] <= 8'h7F;
        mem[10'h102] <= 8'hFF; mem[10'h103] <= 8'h80;
        mem[10'h104] <= 8'h11; mem[10'h105] <= 8'h22;
        mem[10'h106] <= 8'h33; mem[10'h107] <= 8'h44;
        @(negedge clk);
    endtask

    task automatic do_req(input logic sel0, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = uns;
        if (sel0) e_req_valid = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e_req_valid = 1'b0;
        seen_addr.delete();
        seen_sz.delete();
        lat = 0; rd = 32'hDEAD_BEEF; er = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sel0 ? e_rsp_valid : rsp_valid) begin
                lat = k;
                rd  = sel0 ? e_rsp_rdata : rsp_rdata;
                er  = sel0 ? e_rsp_err : rsp_err;
                break;
            end
            seen_addr.push_back(baddr);
            seen_sz.push_back(bsz);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        total++; if (req_ready !== 1'b1 || e_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b exp=11", req_ready, e_req_ready); end
        total++; if ({baddr, bdi, bwr, bsz} !== {64'h0, 1'b0, 2'b10}) begin bad++; $display("FAIL reset_mem_port got=%h/%h/%b/%b exp=0/0/0/10", baddr, bdi, bwr, bsz); end
        total++; if ({e_baddr, e_bdi, e_bwr, e_bsz, e_rsp_valid} !== {64'h0, 1'b0, 2'b10, 1'b0}) begin bad++; $display("FAIL reset_dut0_port got=%h/%h/%b/%b/%b", e_baddr, e_bdi, e_bwr, e_bsz, e_rsp_valid); end
    endtask

    task automatic test_byte_loads();
        logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h103};
        logic        unss  [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] exps  [3] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080};
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 1'b0, addrs[i], 32'h0, 2'b00, unss[i], lat, rd, er);
            total++; if (rd !== exps[i] || er !== 1'b0 || lat != 2) begin bad++; $display("FAIL byte_load%0d got=%h err=%b lat=%0d exp=%h err=0 lat=2", i, rd, er, lat, exps[i]); end
        end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rsp_pulse got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready); end
    endtask

    task automatic test_half_word_loads();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, lat, rd, er);
        total++; if (rd !== 32'hFFFF80FF || er !== 1'b0 || lat != 2) begin bad++; $display("FAIL lh got=%h err=%b lat=%0d exp=ffff80ff/0/2", rd, er, lat); end
        do_req(1'b0, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, lat, rd, er);
        total++; if (rd !== 32'h000080FF || er !== 1'b0 || lat != 2) begin bad++; $display("FAIL lhu got=%h err=%b lat=%0d exp=000080ff/0/2", rd, er, lat); end
        do_req(1'b0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b1, lat, rd, er);
        total++; if (rd !== 32'h80FF7F01 || er !== 1'b0 || lat != 2) begin bad++; $display("FAIL lw got=%h err=%b lat=%0d exp=80ff7f01/0/2", rd, er, lat); end
        total++; if (seen_addr.size() != 1 || seen_addr[0] !== 32'h100 || seen_sz[0] !== 2'b10) begin bad++; $display("FAIL lw_memcycle got n=%0d addr=%h sz=%b exp n=1 addr=100 sz=10", seen_addr.size(), seen_addr[0], seen_sz[0]); end
    endtask

    task automatic test_split_load();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, lat, rd, er);
        total++; if (rd !== 32'h221180FF || er !== 1'b0 || lat != 5) begin bad++; $display("FAIL split_lw got=%h err=%b lat=%0d exp=221180ff/0/5", rd, er, lat); end
        total++;
        if (seen_addr.size() != 4 || seen_addr[0] !== 32'h102 || seen_addr[1] !== 32'h103 ||
            seen_addr[2] !== 32'h104 || seen_addr[3] !== 32'h105 ||
            seen_sz[0] !== 2'b00 || seen_sz[3] !== 2'b00) begin
            bad++; $display("FAIL split_lw_addrs got n=%0d first=%h exp 102..105 bytes", seen_addr.size(), seen_addr[0]);
        end
    endtask

    task automatic test_split_store();
        int lat; logic [31:0] rd; logic er;
        wlog_addr.delete(); wlog_data.delete();
        do_req(1'b0, 1'b1, 32'h0FF, 32'hA1B2C3D4, 2'b10, 1'b0, lat, rd, er);
        total++; if (rd !== 32'h0 || er !== 1'b0 || lat != 5) begin bad++; $display("FAIL split_sw_rsp got=%h err=%b lat=%0d exp=0/0/5", rd, er, lat); end
        total++;
        if (wlog_addr.size() != 4 ||
            {wlog_addr[0], wlog_addr[1], wlog_addr[2], wlog_addr[3]} !== {32'h0FF, 32'h100, 32'h101, 32'h102} ||
            {wlog_data[0], wlog_data[1], wlog_data[2], wlog_data[3]} !== 32'hD4C3B2A1) begin
            bad++; $display("FAIL split_sw_writes got n=%0d first=%h:%h exp 0ff:d4 100:c3 101:b2 102:a1", wlog_addr.size(), wlog_addr[0], wlog_data[0]);
        end
        do_req(1'b0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, lat, rd, er);
        total++; if (rd !== 32'h80A1B2C3 || lat != 2) begin bad++; $display("FAIL lw_after_sw got=%h lat=%0d exp=80a1b2c3/2", rd, lat); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        e_bwr_cnt = 0;
        do_req(1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, lat, rd, er);
        total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL err_misaligned got err=%b rd=%h lat=%0d exp=1/0/1", er, rd, lat); end
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, lat, rd, er);
        total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL err_illsize got err=%b rd=%h lat=%0d exp=1/0/1", er, rd, lat); end
        do_req(1'b1, 1'b1, 32'h101, 32'h12345678, 2'b01, 1'b0, lat, rd, er);
        total++; if (er !== 1'b1 || lat != 1) begin bad++; $display("FAIL err_sh got err=%b lat=%0d exp=1/1", er, lat); end
        total++; if (e_bwr_cnt != 0) begin bad++; $display("FAIL err_no_write got=%0d exp=0", e_bwr_cnt); end
        do_req(1'b0, 1'b1, 32'h100, 32'h0, 2'b11, 1'b0, lat, rd, er);
        total++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL err_illsize_split got err=%b rd=%h lat=%0d exp=1/0/1", er, rd, lat); end
    endtask

    task automatic test_mmio_and_wrap();
        int lat; logic [31:0] rd; logic er;
        wlog_addr.delete(); wlog_data.delete();
        do_req(1'b0, 1'b1, 32'h80000000, 32'h1234565A, 2'b00, 1'b0, lat, rd, er);
        total++; if (lat != 2 || wlog_addr.size() != 1 || wlog_addr[0] !== 32'h80000000 || wlog_data[0] !== 8'h5A) begin bad++; $display("FAIL mmio_sb got lat=%0d n=%0d addr=%h exp lat=2 n=1 addr=80000000 5a", lat, wlog_addr.size(), wlog_addr[0]); end
        mem[10'h3FF] <= 8'hEE; mem[10'h000] <= 8'h01; mem[10'h001] <= 8'h02; mem[10'h002] <= 8'h03;
        do_req(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 2'b10, 1'b0, lat, rd, er);
        total++; if (rd !== 32'h030201EE || lat != 5) begin bad++; $display("FAIL wrap_lw got=%h lat=%0d exp=030201ee/5", rd, lat); end
        total++; if (seen_addr.size() != 4 || seen_addr[0] !== 32'hFFFFFFFF || seen_addr[1] !== 32'h0 || seen_addr[3] !== 32'h2) begin bad++; $display("FAIL wrap_addrs got first=%h second=%h exp ffffffff 0", seen_addr[0], seen_addr[1]); end
    endtask

    task automatic test_reset_mid_split();
        int lat; logic [31:0] rd; logic er; int stray;
        preload();
        wlog_addr.delete(); wlog_data.delete();
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h0FF; req_wdata = 32'hA1B2C3D4; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid) stray++;
            @(negedge clk);
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rst_mid_no_rsp got=%0d exp=0", stray); end
        total++; if (wlog_addr.size() != 2 || {mem[10'h0FF], mem[10'h100], mem[10'h101], mem[10'h102]} !== 32'hD4C37FFF) begin bad++; $display("FAIL rst_mid_mem got n=%0d bytes=%h%h%h%h exp n=2 d4c37fff", wlog_addr.size(), mem[10'h0FF], mem[10'h100], mem[10'h101], mem[10'h102]); end
        do_req(1'b0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, lat, rd, er);
        total++; if (rd !== 32'h80FF7FC3 || er !== 1'b0 || lat != 2) begin bad++; $display("FAIL rst_mid_lw got=%h err=%b lat=%0d exp=80ff7fc3/0/2", rd, er, lat); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; e_req_valid = 1'b0;
        req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b10; req_unsigned = 1'b0;
        preload();
        test_reset();
        test_byte_loads();
        test_half_word_loads();
        test_split_load();
        test_split_store();
        test_errors();
        test_mmio_and_wrap();
        test_reset_mid_split();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
